// File: rtl/pic_pkg.sv
`default_nettype none
//============================================================================
//  Module      : pic_pkg
//  Description : Shared types and constants for the PIC interrupt-acknowledge
//                handshake sequencer (state encoding, timer width, defaults).
//  Revision    : 1.0 - initial release
//============================================================================
package pic_pkg;

    // Handshake sequencer states, binary encoded with explicit width
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        INT_PENDING  = 3'd1,
        WAIT_PRI_ACK = 3'd2,
        WAIT_INTA2   = 3'd3,
        WAIT_VEC_ACK = 3'd4,
        DRIVE        = 3'd5
    } state_t;

    localparam int c_ACK_TIMEOUT_DEFAULT = 16;
    localparam int c_SYNC_STAGES_DEFAULT = 2;
    localparam int c_TIMER_WIDTH         = 8;

    // Timer value on which the ack wait gives up; the timer starts at 0 on
    // state entry, so the abort lands on the ACK_TIMEOUT-th edge in the state.
    function automatic logic [c_TIMER_WIDTH-1:0] timeoutLast(input int timeout);
        return c_TIMER_WIDTH'(timeout - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inta_handshake_sequencer_toggle_ack_detector.sv
`default_nettype none
//============================================================================
//  Module      : toggle_ack_detector
//  Description : Converts a toggle-style acknowledge into a one-cycle
//                "ack seen" indication by comparing against a history flop.
//  Revision    : 1.0 - initial release
//============================================================================
module toggle_ack_detector (
    input  logic clk,
    input  logic reset,
    input  logic i_ack,
    output logic o_ackSeen
);

    logic r_ackHist;

    // History follows the ack line every cycle, regardless of who listens
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ackHist <= 1'b0;
        end else begin
            r_ackHist <= i_ack;
        end
    end

    assign o_ackSeen = i_ack ^ r_ackHist;

endmodule
`default_nettype wire

// File: rtl/inta_handshake_sequencer.sv
`default_nettype none
//============================================================================
//  Module      : inta_handshake_sequencer
//  Description : CPU-side interrupt-acknowledge control of the PIC. Raises
//                INT, turns the two 8086-mode INTA pulses into ISR request
//                strobes, consumes toggle acks and gates the data driver.
//  Revision    : 1.0 - initial release
//============================================================================
module inta_handshake_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
    parameter int ACK_TIMEOUT = c_ACK_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic INTA_n,
    input  logic intRequest,
    input  logic readPriorityAck,
    input  logic sendVectorAck,
    output logic INT,
    output logic readPriority,
    output logic sendVector,
    output logic secondACK,
    output logic dataEnable,
    output logic ackError
);

    localparam logic [c_TIMER_WIDTH-1:0] c_TIMEOUT_LAST = timeoutLast(ACK_TIMEOUT);
    localparam logic [c_TIMER_WIDTH-1:0] c_TIMER_ONE    = c_TIMER_WIDTH'(1);

    logic [SYNC_STAGES-1:0]   r_intaSync;
    logic                     r_intaPrev;
    logic                     r_fallEdge;
    logic                     r_riseEdge;
    logic                     w_intaCur;

    logic                     w_priAckSeen;
    logic                     w_vecAckSeen;

    state_t                   r_state;
    logic [c_TIMER_WIDTH-1:0] r_timer;
    logic                     r_risePending;
    logic                     w_timeoutHit;

    assign w_intaCur    = r_intaSync[SYNC_STAGES-1];
    assign w_timeoutHit = (r_timer == c_TIMEOUT_LAST);

    // INTA_n synchroniser, history flop and registered edge pulses; the edge
    // pulses are flopped so the FSM sees a clean flop-to-flop path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_intaSync <= '1;
            r_intaPrev <= 1'b1;
            r_fallEdge <= 1'b0;
            r_riseEdge <= 1'b0;
        end else begin
            r_intaSync <= {r_intaSync[SYNC_STAGES-2:0], INTA_n};
            r_intaPrev <= w_intaCur;
            r_fallEdge <= r_intaPrev & ~w_intaCur;
            r_riseEdge <= ~r_intaPrev & w_intaCur;
        end
    end

    toggle_ack_detector u_priAckDetect (
        .clk       (clk),
        .reset     (reset),
        .i_ack     (readPriorityAck),
        .o_ackSeen (w_priAckSeen)
    );

    toggle_ack_detector u_vecAckDetect (
        .clk       (clk),
        .reset     (reset),
        .i_ack     (sendVectorAck),
        .o_ackSeen (w_vecAckSeen)
    );

    // Handshake state machine with registered outputs and ack timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_risePending <= 1'b0;
            INT           <= 1'b0;
            readPriority  <= 1'b0;
            sendVector    <= 1'b0;
            secondACK     <= 1'b0;
            dataEnable    <= 1'b0;
            ackError      <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            secondACK <= 1'b0;
            ackError  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (intRequest) begin
                        INT     <= 1'b1;
                        r_state <= INT_PENDING;
                    end
                end

                // INT stays up even if the request vanishes; the ISR answers
                // a vanished request with the spurious vector.
                INT_PENDING: begin
                    if (r_fallEdge) begin
                        readPriority <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= WAIT_PRI_ACK;
                    end
                end

                // Further INTA edges here are dropped, not queued
                WAIT_PRI_ACK: begin
                    if (w_priAckSeen) begin
                        readPriority <= 1'b0;
                        INT          <= 1'b0;
                        r_state      <= WAIT_INTA2;
                    end else if (w_timeoutHit) begin
                        INT           <= 1'b0;
                        readPriority  <= 1'b0;
                        sendVector    <= 1'b0;
                        dataEnable    <= 1'b0;
                        ackError      <= 1'b1;
                        r_timer       <= '0;
                        r_risePending <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end

                WAIT_INTA2: begin
                    if (r_fallEdge) begin
                        sendVector    <= 1'b1;
                        secondACK     <= 1'b1;
                        r_timer       <= '0;
                        r_risePending <= 1'b0;
                        r_state       <= WAIT_VEC_ACK;
                    end
                end

                // A rise seen while still waiting is remembered so that DRIVE
                // lasts exactly one cycle instead of waiting for another rise.
                WAIT_VEC_ACK: begin
                    if (r_riseEdge) begin
                        r_risePending <= 1'b1;
                    end
                    if (w_vecAckSeen) begin
                        sendVector <= 1'b0;
                        dataEnable <= 1'b1;
                        r_state    <= DRIVE;
                    end else if (w_timeoutHit) begin
                        INT           <= 1'b0;
                        readPriority  <= 1'b0;
                        sendVector    <= 1'b0;
                        dataEnable    <= 1'b0;
                        ackError      <= 1'b1;
                        r_timer       <= '0;
                        r_risePending <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end

                DRIVE: begin
                    if (r_riseEdge || r_risePending) begin
                        dataEnable    <= 1'b0;
                        r_risePending <= 1'b0;
                        r_state       <= IDLE;
                    end
                end

                default: begin
                    INT           <= 1'b0;
                    readPriority  <= 1'b0;
                    sendVector    <= 1'b0;
                    dataEnable    <= 1'b0;
                    r_timer       <= '0;
                    r_risePending <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inta_handshake_sequencer.sv
`default_nettype none
//============================================================================
//  Module      : tb_inta_handshake_sequencer
//  Description : Directed self-checking bench for inta_handshake_sequencer.
//                Output vector order: {INT, readPriority, sendVector,
//                secondACK, dataEnable, ackError}.
//  Revision    : 1.0 - initial release
//============================================================================
module tb_inta_handshake_sequencer;
    import pic_pkg::*;

    localparam logic [5:0] c_NONE = 6'b000000;
    localparam logic [5:0] c_INT  = 6'b100000;
    localparam logic [5:0] c_PRI  = 6'b110000;
    localparam logic [5:0] c_SV2  = 6'b001100;
    localparam logic [5:0] c_SV   = 6'b001000;
    localparam logic [5:0] c_DE   = 6'b000010;
    localparam logic [5:0] c_ERR  = 6'b000001;

    logic clk             = 1'b0;
    logic reset           = 1'b1;
    logic INTA_n          = 1'b1;
    logic intRequest      = 1'b0;
    logic readPriorityAck = 1'b0;
    logic sendVectorAck   = 1'b0;
    logic INT, readPriority, sendVector, secondACK, dataEnable, ackError;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } sbEntry_t;

    sbEntry_t scoreboard[$];
    int       vectors     = 0;
    int       miscompares = 0;

    always #5 clk = ~clk;

    inta_handshake_sequencer #(
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .INTA_n          (INTA_n),
        .intRequest      (intRequest),
        .readPriorityAck (readPriorityAck),
        .sendVectorAck   (sendVectorAck),
        .INT             (INT),
        .readPriority    (readPriority),
        .sendVector      (sendVector),
        .secondACK       (secondACK),
        .dataEnable      (dataEnable),
        .ackError        (ackError)
    );

    // Push the expectation for the next edge, advance, then pop and compare
    task automatic step(input string tag, input logic [5:0] exp);
        sbEntry_t   e;
        logic [5:0] obs;
        e.tag = tag;
        e.exp = exp;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        e   = scoreboard.pop_front();
        obs = {INT, readPriority, sendVector, secondACK, dataEnable, ackError};
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
    endtask

    task automatic steps(input int n, input string tag, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            step(tag, exp);
        end
    endtask

    task automatic checkState(input string tag, input state_t exp);
        vectors++;
        assert (dut.r_state === exp) else begin
            miscompares++;
            $error("FAIL %s: observed state %0d expected state %0d", tag, dut.r_state, exp);
        end
    endtask

    // Full two-pulse handshake starting right after INT has risen
    task automatic handshake(input string p, input int priDelay, input int vecDelay);
        INTA_n = 1'b0;
        steps(3, {p, "_intHeld"}, c_INT);
        step({p, "_rpRise"}, c_PRI);
        INTA_n = 1'b1;
        steps(1 + priDelay, {p, "_rpHold"}, c_PRI);
        readPriorityAck = ~readPriorityAck;
        step({p, "_rpDrop"}, c_NONE);
        steps(2, {p, "_gapA"}, c_NONE);
        INTA_n = 1'b0;
        steps(3, {p, "_gapB"}, c_NONE);
        step({p, "_sv2"}, c_SV2);
        INTA_n = 1'b1;
        step({p, "_sv"}, c_SV);
        steps(vecDelay, {p, "_svHold"}, c_SV);
        sendVectorAck = ~sendVectorAck;
        step({p, "_de"}, c_DE);
        if (vecDelay == 0) begin
            step({p, "_deHold"}, c_DE);
        end
        step({p, "_end"}, c_NONE);
        checkState({p, "_state"}, IDLE);
    endtask

    initial begin
        // Reset state
        step("rst0", c_NONE);
        step("rst1", c_NONE);
        checkState("rstState", IDLE);
        reset = 1'b0;
        step("idle", c_NONE);

        // Nominal sequence with request held, then back-to-back re-rise
        intRequest = 1'b1;
        step("nomIntRise", c_INT);
        handshake("nom", 0, 0);
        step("b2bIntRise", c_INT);

        // Spurious: request drops before INTA; rise coincides with vector ack
        intRequest = 1'b0;
        handshake("spur", 0, 2);
        step("spurIdle", c_NONE);

        // Stray ack toggle while idle must not satisfy the later wait
        readPriorityAck = ~readPriorityAck;
        step("strayIdle", c_NONE);
        step("strayIdle2", c_NONE);
        intRequest = 1'b1;
        step("strayIntRise", c_INT);
        intRequest = 1'b0;
        handshake("stray", 4, 0);

        // Timeout in WAIT_PRI_ACK with a second INTA fall that is ignored
        intRequest = 1'b1;
        step("toIntRise", c_INT);
        intRequest = 1'b0;
        INTA_n = 1'b0;
        steps(3, "toIntHeld", c_INT);
        step("toRpRise", c_PRI);
        INTA_n = 1'b1;
        steps(4, "toHoldA", c_PRI);
        INTA_n = 1'b0;
        steps(4, "toHoldB", c_PRI);
        INTA_n = 1'b1;
        steps(7, "toHoldC", c_PRI);
        step("toErr", c_ERR);
        checkState("toState", IDLE);
        step("toErrPulse", c_NONE);
        steps(4, "toQuiet", c_NONE);

        // Reset asserted in WAIT_VEC_ACK with sendVector high
        intRequest = 1'b1;
        step("rmIntRise", c_INT);
        intRequest = 1'b0;
        INTA_n = 1'b0;
        steps(3, "rmIntHeld", c_INT);
        step("rmRpRise", c_PRI);
        INTA_n = 1'b1;
        step("rmRpHold", c_PRI);
        readPriorityAck = ~readPriorityAck;
        step("rmRpDrop", c_NONE);
        steps(2, "rmGapA", c_NONE);
        INTA_n = 1'b0;
        steps(3, "rmGapB", c_NONE);
        step("rmSv2", c_SV2);
        step("rmSv", c_SV);
        checkState("rmWaitVec", WAIT_VEC_ACK);
        reset  = 1'b1;
        INTA_n = 1'b1;
        step("rmReset", c_NONE);
        checkState("rmState", IDLE);
        reset = 1'b0;
        steps(3, "rmQuiet", c_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
